// File: rtl/rc_writeback_stage.sv
// Writeback stage of a reconfigurable cell: commits ALU results to the RC output
// register and local RF, sequences multi-cycle ops, and returns registered flags.
module rc_writeback_stage #(
  parameter int unsigned DP_WIDTH    = 32,
  parameter int unsigned N_RF        = 4,
  parameter int unsigned MULT_CYCLES = 2,
  parameter int unsigned BR_ADD_W    = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      exec_i,
  input  logic [DP_WIDTH-1:0]       alu_res_i,
  input  logic [1:0]                alu_flag_i,
  input  logic                      br_req_i,
  input  logic [BR_ADD_W-1:0]       br_add_i,
  input  logic                      alu_stall_i,
  input  logic                      out_we_i,
  input  logic                      rf_we_i,
  input  logic [$clog2(N_RF)-1:0]   rf_waddr_i,
  input  logic [$clog2(N_RF)-1:0]   rf_raddr_i,
  output logic [DP_WIDTH-1:0]       rf_rdata_o,
  output logic [DP_WIDTH-1:0]       rc_res_o,
  output logic [1:0]                flag_o,
  output logic                      br_req_o,
  output logic [BR_ADD_W-1:0]       br_add_o,
  output logic                      stall_o,
  output logic                      done_o
);

  localparam int unsigned AW    = $clog2(N_RF);
  localparam int unsigned CNT_W = $clog2(MULT_CYCLES) + 1;
  localparam logic        MULTI = 1'(MULT_CYCLES > 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MWAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic          out_we;
    logic          rf_we;
    logic [AW-1:0] waddr;
  } wr_ctl_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  wr_ctl_t             ctl_in;
  wr_ctl_t             ctl_q;
  wr_ctl_t             ctl_commit;
  logic                start;
  logic                commit;
  logic [DP_WIDTH-1:0] rf [N_RF];

  assign ctl_in = '{out_we: out_we_i, rf_we: rf_we_i, waddr: rf_waddr_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (exec_i && alu_stall_i && MULTI) begin
          state_nxt = S_MWAIT;
        end
      end
      S_MWAIT: begin
        if (cnt == CNT_ONE) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded control: multiply start, commit strobe, stall and write controls in use
  always_comb begin
    start      = 1'b0;
    commit     = 1'b0;
    stall_o    = 1'b0;
    ctl_commit = ctl_in;
    case (state)
      S_IDLE: begin
        start   = exec_i & alu_stall_i & MULTI;
        commit  = exec_i & ~start;
        stall_o = start;
      end
      S_MWAIT: begin
        stall_o    = (cnt > CNT_ONE);
        commit     = (cnt == CNT_ONE);
        ctl_commit = ctl_q;
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

  // Multiply countdown and captured write controls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt   <= '0;
      ctl_q <= '0;
    end else if (start) begin
      cnt   <= CNT_LOAD;
      ctl_q <= ctl_in;
    end else if (state == S_MWAIT) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Result, flag and branch registers; branch and done are single-cycle pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc_res_o <= '0;
      flag_o   <= '0;
      br_req_o <= 1'b0;
      br_add_o <= '0;
      done_o   <= 1'b0;
    end else if (commit) begin
      if (ctl_commit.out_we) begin
        rc_res_o <= alu_res_i;
      end
      flag_o   <= alu_flag_i;
      br_req_o <= br_req_i;
      br_add_o <= br_req_i ? br_add_i : '0;
      done_o   <= 1'b1;
    end else begin
      br_req_o <= 1'b0;
      br_add_o <= '0;
      done_o   <= 1'b0;
    end
  end

  // Local register file; reads see the stored value, never the one being written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_RF; i++) begin
        rf[i] <= '0;
      end
    end else if (commit && ctl_commit.rf_we) begin
      rf[ctl_commit.waddr] <= alu_res_i;
    end
  end

  assign rf_rdata_o = rf[rf_raddr_i];

endmodule

// File: tb/tb_rc_writeback_stage.sv
// Bench for rc_writeback_stage: directed scenarios plus random traffic, checked
// against a transaction-level model that tracks commits by absolute cycle number.
module tb_rc_writeback_stage;

  localparam int unsigned DW  = 32;
  localparam int unsigned NRF = 4;
  localparam int unsigned MC  = 2;
  localparam int unsigned BW  = 5;
  localparam int unsigned AW  = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          exec_i;
  logic [DW-1:0] alu_res_i;
  logic [1:0]    alu_flag_i;
  logic          br_req_i;
  logic [BW-1:0] br_add_i;
  logic          alu_stall_i;
  logic          out_we_i;
  logic          rf_we_i;
  logic [AW-1:0] rf_waddr_i;
  logic [AW-1:0] rf_raddr_i;
  logic [DW-1:0] rf_rdata_o;
  logic [DW-1:0] rc_res_o;
  logic [1:0]    flag_o;
  logic          br_req_o;
  logic [BW-1:0] br_add_o;
  logic          stall_o;
  logic          done_o;

  rc_writeback_stage #(
    .DP_WIDTH(DW), .N_RF(NRF), .MULT_CYCLES(MC), .BR_ADD_W(BW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .exec_i(exec_i), .alu_res_i(alu_res_i),
    .alu_flag_i(alu_flag_i), .br_req_i(br_req_i), .br_add_i(br_add_i),
    .alu_stall_i(alu_stall_i), .out_we_i(out_we_i), .rf_we_i(rf_we_i),
    .rf_waddr_i(rf_waddr_i), .rf_raddr_i(rf_raddr_i), .rf_rdata_o(rf_rdata_o),
    .rc_res_o(rc_res_o), .flag_o(flag_o), .br_req_o(br_req_o), .br_add_o(br_add_o),
    .stall_o(stall_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_rf [NRF];
  logic [DW-1:0] m_res;
  logic [1:0]    m_flag;
  logic          m_br;
  logic [BW-1:0] m_badd;
  logic          m_done;
  bit            busy;
  int            cyc;
  int            commit_cyc;
  bit            l_owe;
  bit            l_rwe;
  logic [AW-1:0] l_wa;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRF; i++) m_rf[i] = '0;
    m_res  = '0;
    m_flag = '0;
    m_br   = 1'b0;
    m_badd = '0;
    m_done = 1'b0;
    busy   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, then registered ones
  task automatic step(input bit rst, input bit ex, input bit st, input logic [DW-1:0] res,
                      input logic [1:0] fl, input bit br, input logic [BW-1:0] ba,
                      input bit owe, input bit rwe, input logic [AW-1:0] wa,
                      input logic [AW-1:0] ra);
    bit            start;
    bit            commit;
    bit            c_owe;
    bit            c_rwe;
    logic [AW-1:0] c_wa;
    bit            exp_stall;
    @(negedge clk);
    rst_i = rst; exec_i = ex; alu_stall_i = st; alu_res_i = res; alu_flag_i = fl;
    br_req_i = br; br_add_i = ba; out_we_i = owe; rf_we_i = rwe;
    rf_waddr_i = wa; rf_raddr_i = ra;
    start = !busy && ex && st && (MC > 1);
    if (busy) begin
      exp_stall = (cyc < commit_cyc);
      commit    = (cyc == commit_cyc);
      c_owe = l_owe; c_rwe = l_rwe; c_wa = l_wa;
    end else begin
      exp_stall = start;
      commit    = ex && !start;
      c_owe = owe; c_rwe = rwe; c_wa = wa;
    end
    #1;
    chk("stall", DW'(stall_o), DW'(exp_stall));
    chk("rf_rdata", rf_rdata_o, m_rf[ra]);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (start) begin
        busy = 1'b1; commit_cyc = cyc + int'(MC) - 1;
        l_owe = owe; l_rwe = rwe; l_wa = wa;
      end
      if (commit) begin
        busy = 1'b0;
        if (c_owe) m_res = res;
        if (c_rwe) m_rf[c_wa] = res;
        m_flag = fl;
        m_br   = br;
        m_badd = br ? ba : '0;
        m_done = 1'b1;
      end else begin
        m_br = 1'b0; m_badd = '0; m_done = 1'b0;
      end
    end
    cyc++;
    #1;
    chk("rc_res", rc_res_o, m_res);
    chk("flag", DW'(flag_o), DW'(m_flag));
    chk("br_req", DW'(br_req_o), DW'(m_br));
    chk("br_add", DW'(br_add_o), DW'(m_badd));
    chk("done", DW'(done_o), DW'(m_done));
  endtask

  task automatic idle(input logic [AW-1:0] ra);
    step(1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0, '0, 1'b0, 1'b0, '0, ra);
  endtask

  initial begin
    rst_i = 1'b1; exec_i = 1'b0; alu_res_i = '0; alu_flag_i = '0; br_req_i = 1'b0;
    br_add_i = '0; alu_stall_i = 1'b0; out_we_i = 1'b0; rf_we_i = 1'b0;
    rf_waddr_i = '0; rf_raddr_i = '0;
    cyc = 0; commit_cyc = 0; l_owe = 1'b0; l_rwe = 1'b0; l_wa = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // 1: reset state, every RF entry reads zero
    for (int i = 0; i < NRF; i++) idle(AW'(i));
    chk("t1_rc_res", rc_res_o, 32'h0);
    chk("t1_stall", DW'(stall_o), 32'h0);

    // 2: single-cycle ADD to the output register
    step(1'b0, 1'b1, 1'b0, 32'h7, 2'b00, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    chk("t2_rc_res", rc_res_o, 32'h7);
    chk("t2_done", DW'(done_o), 32'h1);
    idle('0);
    chk("t2_done_pulse", DW'(done_o), 32'h0);

    // 3: stalling multiply into RF[2]
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA, 2'b10, 1'b0, '0, 1'b0, 1'b1, 2'd2, 2'd2);
    chk("t3_stall_c1", DW'(stall_o), 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFA, 2'b10, 1'b0, '0, 1'b0, 1'b0, '0, 2'd2);
    chk("t3_flag", DW'(flag_o), 32'h2);
    chk("t3_rf2", rf_rdata_o, 32'hFFFF_FFFA);
    idle(2'd2);

    // 4: branch request pulse
    step(1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b1, 5'd9, 1'b0, 1'b0, '0, '0);
    chk("t4_br_req", DW'(br_req_o), 32'h1);
    chk("t4_br_add", DW'(br_add_o), 32'h9);
    idle('0);
    chk("t4_br_pulse", DW'(br_req_o), 32'h0);

    // 5: reset while a multiply is outstanding
    step(1'b0, 1'b1, 1'b1, 32'h1234, 2'b00, 1'b1, 5'd3, 1'b1, 1'b1, 2'd1, '0);
    step(1'b1, 1'b1, 1'b1, 32'h1234, 2'b00, 1'b1, 5'd3, 1'b1, 1'b1, 2'd1, 2'd1);
    chk("t5_done", DW'(done_o), 32'h0);
    chk("t5_rc_res", rc_res_o, 32'h0);
    idle(2'd1);
    chk("t5_rf1", rf_rdata_o, 32'h0);

    // 6: back-to-back commits, then simultaneous output and RF write
    for (int v = 1; v <= 3; v++) begin
      step(1'b0, 1'b1, 1'b0, DW'(v), 2'b00, 1'b0, '0, 1'b1, 1'b0, '0, '0);
      chk("t6_seq", rc_res_o, DW'(v));
    end
    step(1'b0, 1'b1, 1'b0, 32'hAB, 2'b00, 1'b0, '0, 1'b1, 1'b1, 2'd1, 2'd1);
    chk("t6_both_res", rc_res_o, 32'hAB);
    chk("t6_both_rf", rf_rdata_o, 32'hAB);
    step(1'b0, 1'b1, 1'b0, 32'hCD, 2'b00, 1'b0, '0, 1'b0, 1'b1, 2'd1, 2'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit            r_rst;
      bit            r_ex;
      bit            r_st;
      bit            r_br;
      bit            r_owe;
      bit            r_rwe;
      logic [DW-1:0] r_res;
      logic [1:0]    r_fl;
      logic [BW-1:0] r_ba;
      logic [AW-1:0] r_wa;
      logic [AW-1:0] r_ra;
      r_rst = ($urandom_range(0, 49) == 0);
      r_ex  = ($urandom_range(0, 9) < 6);
      r_st  = ($urandom_range(0, 2) == 0);
      r_br  = ($urandom_range(0, 3) == 0);
      r_owe = ($urandom_range(0, 1) == 0);
      r_rwe = ($urandom_range(0, 1) == 0);
      r_res = $urandom;
      r_fl  = 2'($urandom);
      r_ba  = BW'($urandom);
      r_wa  = AW'($urandom);
      r_ra  = AW'($urandom);
      step(r_rst, r_ex, r_st, r_res, r_fl, r_br, r_ba, r_owe, r_rwe, r_wa, r_ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
